// File: rtl/barcode_scan_ctrl.sv
// barcode_scan_ctrl: judges bar/space runs on three scan rows per frame and drives a debounced scan_en.
// Define SCAN_HOLD_EN to keep scan_en high until MISS_FRAMES consecutive bad frames.
module barcode_scan_ctrl #(
  parameter logic [9:0] BAR_LOC_Y1    = 10'd84,
  parameter logic [9:0] BAR_LOC_Y2    = 10'd104,
  parameter logic [9:0] BAR_LOC_Y3    = 10'd134,
  parameter logic [7:0] BAR_NUM       = 8'd30,
  parameter logic [9:0] MIN_W         = 10'd2,
  parameter logic [9:0] MAX_W         = 10'd40,
  parameter logic [3:0] STABLE_FRAMES = 4'd3,
  parameter logic [3:0] MISS_FRAMES   = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic       in_vs,
  input  logic       in_de,
  input  logic       in_data,
  output logic       scan_en,
  output logic       frame_done,
  output logic [2:0] row_ok,
  output logic [7:0] bar_count
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_ROW = 2'd1, SCAN = 2'd2, EVAL = 2'd3;
  logic [1:0] state, row_idx;
  logic       vs_d, data_d, bad;
  logic [9:0] run, row_y;
  logic [7:0] bars, bar_cnt_next;
  logic [2:0] row_ok_next;
  logic [3:0] good_cnt;
  logic       vs_rise, trans, width_bad, row_pass, good;
`ifdef SCAN_HOLD_EN
  logic [3:0] miss_cnt;
`endif
  logic       unused;
  assign unused = ^{x_in, MISS_FRAMES};
  always_comb begin
    vs_rise   = in_vs & ~vs_d;
    trans     = in_de & (in_data != data_d);
    row_y     = row_idx == 2'd0 ? BAR_LOC_Y1 : row_idx == 2'd1 ? BAR_LOC_Y2 : BAR_LOC_Y3;
    width_bad = (run < MIN_W) || (run > MAX_W);
    row_pass  = (bars == BAR_NUM) && !bad && !data_d;
    good      = &row_ok_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      row_idx      <= 2'd0;
      vs_d         <= 1'b0;
      data_d       <= 1'b0;
      bad          <= 1'b0;
      run          <= 10'd0;
      bars         <= 8'd0;
      bar_cnt_next <= 8'd0;
      row_ok_next  <= 3'd0;
      good_cnt     <= 4'd0;
      scan_en      <= 1'b0;
      frame_done   <= 1'b0;
      row_ok       <= 3'd0;
      bar_count    <= 8'd0;
`ifdef SCAN_HOLD_EN
      miss_cnt     <= 4'd0;
`endif
    end else begin
      vs_d       <= in_vs;
      data_d     <= in_data;
      frame_done <= 1'b0;
      // a frame boundary always restarts the row sequence, aborting any partial frame
      if (vs_rise) begin
        state        <= WAIT_ROW;
        row_idx      <= 2'd0;
        row_ok_next  <= 3'd0;
        bar_cnt_next <= 8'd0;
      end else begin
        case (state)
          WAIT_ROW: if (in_de && y_in == row_y) begin
            state <= SCAN;
            run   <= 10'd1;
            bars  <= {7'd0, in_data};
            bad   <= 1'b0;
          end
          SCAN: if (!in_de) begin
            row_ok_next[row_idx] <= row_pass;
            if (row_idx == 2'd0) bar_cnt_next <= bars;
            row_idx <= row_idx + 2'd1;
            state   <= row_idx == 2'd2 ? EVAL : WAIT_ROW;
          end else if (trans) begin
            run <= 10'd1;
            if (in_data) bars <= bars == 8'hff ? bars : bars + 8'd1;
            // white runs before the first bar are margin, not spaces
            if ((!in_data || bars != 8'd0) && width_bad) bad <= 1'b1;
          end else begin
            run <= run == 10'h3ff ? run : run + 10'd1;
          end
          EVAL: begin
            state      <= IDLE;
            frame_done <= 1'b1;
            row_ok     <= row_ok_next;
            bar_count  <= bar_cnt_next;
            if (good) begin
              good_cnt <= good_cnt == STABLE_FRAMES ? good_cnt : good_cnt + 4'd1;
              if (good_cnt + 4'd1 >= STABLE_FRAMES) scan_en <= 1'b1;
`ifdef SCAN_HOLD_EN
              miss_cnt <= 4'd0;
`endif
            end else begin
              good_cnt <= 4'd0;
`ifdef SCAN_HOLD_EN
              if (scan_en) begin
                miss_cnt <= miss_cnt + 4'd1;
                if (miss_cnt + 4'd1 >= MISS_FRAMES) begin
                  scan_en  <= 1'b0;
                  miss_cnt <= 4'd0;
                end
              end
`else
              scan_en <= 1'b0;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_barcode_scan_ctrl.sv
// tb_barcode_scan_ctrl: directed + randomized frames checked against a run-length reference model.
module tb_barcode_scan_ctrl;
  localparam int MIN_W = 2, MAX_W = 40, BAR_NUM = 30, STABLE = 3, MISS = 4;
  logic       clk, rst, in_vs, in_de, in_data;
  logic [9:0] x_in, y_in;
  logic       scan_en, frame_done;
  logic [2:0] row_ok;
  logic [7:0] bar_count;
  bit         pix[3][512];
  int         len[3];
  int         checks, errors, done_cnt, exp_done;
  int         good_run, miss_run;
  logic       exp_en;
  logic [2:0] exp_row_ok;
  logic [7:0] exp_bars;

  barcode_scan_ctrl dut (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .in_vs(in_vs), .in_de(in_de),
    .in_data(in_data), .scan_en(scan_en), .frame_done(frame_done), .row_ok(row_ok),
    .bar_count(bar_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] row_y(input int r);
    return r == 0 ? 10'd84 : r == 1 ? 10'd104 : 10'd134;
  endfunction

  // kind: 0 normal, 1 one internal space of width 1, 2 ends on black, 3 one bar of width 41
  task automatic build_row(input int r, input int nb, input int wlo, input int whi, input int kind);
    int p, w, s;
    p = 0;
    repeat ($urandom_range(8, 3)) begin pix[r][p] = 1'b0; p++; end
    for (int b = 0; b < nb; b++) begin
      w = (kind == 3 && b == nb / 2) ? 41 : int'($urandom_range(whi, wlo));
      repeat (w) begin pix[r][p] = 1'b1; p++; end
      if (!(kind == 2 && b == nb - 1)) begin
        s = (kind == 1 && b == nb / 2) ? 1 : int'($urandom_range(whi, wlo));
        repeat (s) begin pix[r][p] = 1'b0; p++; end
      end
    end
    len[r] = p;
  endtask

  task automatic good_rows(input int wlo, input int whi);
    for (int r = 0; r < 3; r++) build_row(r, BAR_NUM, wlo, whi, 0);
  endtask

  // split the row into runs, then apply the pass rules to the run list
  task automatic judge(input int r, output bit pass, output int bars);
    int runs[$];
    bit col[$];
    runs = {};
    col = {};
    for (int p = 0; p < len[r]; p++)
      if (p == 0 || pix[r][p] != pix[r][p-1]) begin runs.push_back(1); col.push_back(pix[r][p]); end
      else runs[runs.size()-1] += 1;
    bars = 0;
    pass = 1'b1;
    foreach (col[i]) if (col[i]) bars++;
    for (int i = 0; i < runs.size() - 1; i++)
      if (!(i == 0 && !col[0]) && (runs[i] < MIN_W || runs[i] > MAX_W)) pass = 1'b0;
    if (col[col.size()-1]) pass = 1'b0;
    if (bars != BAR_NUM) pass = 1'b0;
  endtask

  task automatic model_frame();
    bit ok;
    int bars;
    for (int r = 0; r < 3; r++) begin
      judge(r, ok, bars);
      exp_row_ok[r] = ok;
      if (r == 0) exp_bars = bars > 255 ? 8'd255 : 8'(bars);
    end
    if (&exp_row_ok) begin
      if (good_run < STABLE) good_run++;
      miss_run = 0;
      if (good_run == STABLE) exp_en = 1'b1;
    end else begin
      good_run = 0;
`ifdef SCAN_HOLD_EN
      if (exp_en) begin
        miss_run++;
        if (miss_run == MISS) begin exp_en = 1'b0; miss_run = 0; end
      end
`else
      exp_en = 1'b0;
`endif
    end
  endtask

  task automatic vs_pulse();
    y_in = 10'd0; in_de = 1'b0; in_data = 1'b0;
    in_vs = 1'b1; tick(); tick();
    in_vs = 1'b0; tick();
  endtask

  task automatic drive_px(input int r, input int p0, input int p1);
    for (int p = p0; p < p1; p++) begin
      in_de = 1'b1; in_data = pix[r][p]; x_in = 10'(p);
      tick();
    end
  endtask

  task automatic drive_row(input int r);
    y_in = row_y(r); in_de = 1'b0; in_data = 1'b0;
    repeat (3) tick();
    drive_px(r, 0, len[r]);
    in_de = 1'b0; in_data = 1'b0;
    tick();
  endtask

  task automatic frame(input bit abort);
    vs_pulse();
    drive_row(0);
    drive_row(1);
    if (abort) begin
      vs_pulse();
      drive_row(2);
      repeat (4) tick();
      check("abort_no_done", done_cnt, exp_done);
    end else begin
      drive_row(2);
      model_frame();
      tick();
      check("frame_done", {31'd0, frame_done}, 1);
      check("row_ok", {29'd0, row_ok}, {29'd0, exp_row_ok});
      check("bar_count", {24'd0, bar_count}, {24'd0, exp_bars});
      check("scan_en", {31'd0, scan_en}, {31'd0, exp_en});
      tick();
      exp_done++;
      check("done_pulses", done_cnt, exp_done);
      check("frame_done_low", {31'd0, frame_done}, 0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_scan_en"}, {31'd0, scan_en}, 0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 0);
    check({tag, "_row_ok"}, {29'd0, row_ok}, 0);
    check({tag, "_bar_count"}, {24'd0, bar_count}, 0);
  endtask

  initial begin
    int h, kind, row;
    checks = 0; errors = 0; done_cnt = 0; exp_done = 0;
    good_run = 0; miss_run = 0; exp_en = 1'b0; exp_row_ok = 3'd0; exp_bars = 8'd0;
    rst = 1'b1; in_vs = 1'b0; in_de = 1'b0; in_data = 1'b0; x_in = 10'd0; y_in = 10'd0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    for (int f = 0; f < 3; f++) begin good_rows(4, 4); frame(0); end
    good_rows(4, 4); build_row(1, 29, 4, 4, 0); frame(0);
    repeat (3) begin good_rows(2, 6); frame(0); end
    good_rows(2, 6); build_row(2, BAR_NUM, 2, 6, 1); frame(0);
    good_rows(2, 6); frame(0);
    good_rows(3, 5); build_row(0, BAR_NUM, 3, 5, 2); frame(0);
    good_rows(3, 5); build_row(0, BAR_NUM, 3, 5, 3); frame(0);
    good_rows(3, 5); frame(1);
    good_rows(3, 5); frame(0);
    // reset in the middle of row Y2, then let the rest of the frame play out
    good_rows(3, 5);
    vs_pulse();
    drive_row(0);
    y_in = row_y(1); repeat (3) tick();
    h = len[1] / 2;
    drive_px(1, 0, h);
    rst = 1'b1; in_de = 1'b1; in_data = pix[1][h];
    tick();
    rst = 1'b0;
    check_zero("mid_reset");
    good_run = 0; miss_run = 0; exp_en = 1'b0;
    drive_px(1, h + 1, len[1]);
    in_de = 1'b0; in_data = 1'b0; tick();
    drive_row(2);
    repeat (4) tick();
    check("mid_reset_no_done", done_cnt, exp_done);
    good_rows(3, 5); frame(0);
    repeat (8) begin
      kind = int'($urandom_range(3, 0));
      row = int'($urandom_range(2, 0));
      good_rows(2, 6);
      if (kind != 0) build_row(row, BAR_NUM, 2, 6, kind);
      frame(0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
